seq_matcher: RTL and testbench
==============================

# seq_matcher

Recall checker for the button-sequence demo. It holds up to DEPTH 2-bit entries, pushed by the recording side in write order. It then compares debounced button presses from the player against those entries, in the same order, and reports pass or fail. It sits between the debouncers and the LEDs, on the consuming end of the sequence store that the recorder fills.

## Interface
- DEPTH, 8, maximum stored entries
- AW, 3, entry address width (2^AW = DEPTH)
- COUNT_WIDTH, 24, width of the inactivity timeout counter
- TIMEOUT_COUNT, 24'd11999999, idle cycles allowed between presses in CHECK
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  one-cycle pulse: erase the stored sequence, return to IDLE
- ld_valid  input  1  one-cycle pulse: store ld_data as the next entry
- ld_data  input  2  entry value
- in_valid  input  1  one-cycle pulse: one player press (debounced down-edge)
- in_data  input  2  button levels sampled with in_valid
- leds  output  2  display value
- pass  output  1  high in PASS
- fail  output  1  high in FAIL
- busy  output  1  high in CHECK
- num_seqs  output  AW+1  stored entry count, saturates at DEPTH
- progress  output  AW+1  entries matched in the current attempt

## Operation
- States: IDLE (num_seqs=0), ARMED, CHECK, PASS, FAIL. Reset enters IDLE.
- Storage: register array mem[DEPTH], write pointer w_addr (AW bits), match index idx (AW+1 bits).
- Load, accepted only in IDLE or ARMED:
  - ld_valid writes mem[w_addr], then increments w_addr modulo DEPTH.
  - num_seqs increments, saturating at DEPTH.
  - Any load leaves the state as ARMED.
  - The 9th and later loads overwrite mem[0], mem[1], and so on.
- Loads in CHECK, PASS or FAIL are ignored.
- Matching always compares against mem[0..num_seqs-1] in address order.
- Attempt start:
  - in_valid in ARMED, PASS or FAIL starts an attempt: idx is set to 0, then the press is evaluated as entry 0.
  - in_valid in IDLE is ignored.
- Evaluating a press against entry idx:
  - in_data == mem[idx] and idx+1 == num_seqs: go to PASS, progress=num_seqs.
  - in_data == mem[idx] otherwise: go to (or stay in) CHECK, idx and progress increment.
  - in_data != mem[idx]: go to FAIL, progress keeps its last value.
  - With num_seqs=1 the first press decides PASS or FAIL.
- PASS and FAIL hold until clr or the next in_valid.
- leds:
  - 2'b00 in IDLE and ARMED.
  - In CHECK, the last accepted in_data (echo).
  - 2'b01 in PASS, 2'b10 in FAIL.
- Simultaneous events:
  - clr beats everything. It zeroes w_addr, num_seqs, idx, progress and all outputs; memory contents are don't-care.
  - in_valid beats ld_valid in ARMED; the load is dropped.
- rst_n low at any point, including mid-attempt: all registers clear immediately, state goes to IDLE.

## Timing
- All outputs are registered. Reset values: leds=0, pass=0, fail=0, busy=0, num_seqs=0, progress=0.
- Latency: an input sampled on edge N is reflected on the outputs after edge N; visible during cycle N+1.
- A load at edge N is matchable by an in_valid at edge N+1.
- Input pulses are expected to be exactly one cycle; a held level counts as one event per cycle.
- No handshake back to the sources; events that are not accepted are silently dropped.
- num_seqs arithmetic is AW+1 bits and never exceeds DEPTH. w_addr wraps naturally at AW bits.

## Configuration
- SEQ_MATCHER_TIMEOUT_EN defined:
  - A COUNT_WIDTH-bit counter runs only in CHECK and clears on every accepted in_valid and on entry to CHECK.
  - When the counter equals TIMEOUT_COUNT, the state goes to FAIL on the next edge, with progress unchanged.
  - The counter clears on reset and on clr.
- SEQ_MATCHER_TIMEOUT_EN undefined:
  - No counter is built; CHECK waits indefinitely.
  - TIMEOUT_COUNT and COUNT_WIDTH are unused.

## Test plan
- Reset, then load 2'b01, 2'b10, 2'b11 and press 01, 10, 11 -> busy during the presses, then pass=1, leds=2'b01, progress=3, num_seqs=3.
- Same load, press 01 then 11 -> fail=1, leds=2'b10, progress=1. A further press of 01, 10, 11 then reaches PASS.
- Load 10 values 0,1,2,3,0,1,2,3,2,1 -> num_seqs=8, mem[0]=2, mem[1]=1. Presses 2,1,2,3,0,1,2,3 -> PASS.
- ld_valid and in_valid in the same ARMED cycle -> num_seqs unchanged, press evaluated. clr during CHECK -> next cycle IDLE, all outputs 0.
- With SEQ_MATCHER_TIMEOUT_EN and TIMEOUT_COUNT=20: one correct press, then no input -> fail=1 exactly 21 cycles after the press edge. Without the macro: still busy after 1000 cycles.
- Assert rst_n low mid-attempt asynchronously -> outputs 0 before the next clk edge. In-attempt presses after release are ignored until a new load arrives.

Source files
------------

// File: rtl/seq_matcher.sv
// Recall checker: stores up to DEPTH 2-bit entries, then matches player presses against them in order.
// Optional inactivity timeout in CHECK is built when SEQ_MATCHER_TIMEOUT_EN is defined.
module seq_matcher #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH-1:0] TIMEOUT_COUNT = 24'd11999999
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          ld_valid,
  input  logic [1:0]    ld_data,
  input  logic          in_valid,
  input  logic [1:0]    in_data,
  output logic [1:0]    leds,
  output logic          pass,
  output logic          fail,
  output logic          busy,
  output logic [AW:0]   num_seqs,
  output logic [AW:0]   progress
);

  localparam int unsigned NW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_CHECK = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] w_addr, w_addr_d;
  logic [NW-1:0] idx, idx_d;
  logic [NW-1:0] num_seqs_d, progress_d;
  logic [1:0]    leds_d;
  logic          pass_d, fail_d, busy_d;
  logic          mem_we;
  logic          do_load, do_press;
  logic [NW-1:0] idx_eval;
  logic [1:0]    exp_data;
  logic          hit, last;
  logic          timeout_hit;

`ifdef SEQ_MATCHER_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] tmo_cnt, tmo_cnt_d;

  // Idle counter only advances while waiting for the next press in CHECK
  always_comb begin
    tmo_cnt_d = '0;
    if (!clr && state == S_CHECK && state_d == S_CHECK && !do_press)
      tmo_cnt_d = tmo_cnt + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt <= '0;
    else        tmo_cnt <= tmo_cnt_d;
  end

  assign timeout_hit = (state == S_CHECK) && (tmo_cnt == TIMEOUT_COUNT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_COUNT;
  assign timeout_hit = 1'b0;
`endif

  // A press restarts from entry 0 unless an attempt is already in progress
  assign idx_eval = (state == S_CHECK) ? idx : '0;
  assign exp_data = mem[idx_eval[AW-1:0]];
  assign hit      = (in_data == exp_data);
  assign last     = ((idx_eval + NW'(1)) == num_seqs);
  assign do_press = in_valid && (state != S_IDLE);
  assign do_load  = ld_valid && ((state == S_IDLE) || (state == S_ARMED && !in_valid));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state;
    w_addr_d   = w_addr;
    num_seqs_d = num_seqs;
    idx_d      = idx;
    progress_d = progress;
    mem_we     = 1'b0;
    leds_d     = leds;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    busy_d     = 1'b0;

    if (clr) begin
      state_d    = S_IDLE;
      w_addr_d   = '0;
      num_seqs_d = '0;
      idx_d      = '0;
      progress_d = '0;
    end else if (do_press) begin
      if (!hit) begin
        state_d = S_FAIL;
        idx_d   = '0;
      end else if (last) begin
        state_d    = S_PASS;
        idx_d      = '0;
        progress_d = num_seqs;
      end else begin
        state_d    = S_CHECK;
        idx_d      = idx_eval + NW'(1);
        progress_d = idx_eval + NW'(1);
      end
    end else if (do_load) begin
      mem_we   = 1'b1;
      w_addr_d = w_addr + AW'(1);
      if (num_seqs != NW'(DEPTH))
        num_seqs_d = num_seqs + NW'(1);
      state_d  = S_ARMED;
    end else if (timeout_hit) begin
      state_d = S_FAIL;
      idx_d   = '0;
    end

    case (state_d)
      S_PASS:  leds_d = 2'b01;
      S_FAIL:  leds_d = 2'b10;
      S_CHECK: leds_d = do_press ? in_data : leds;
      default: leds_d = 2'b00;
    endcase
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
    busy_d = (state_d == S_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      w_addr   <= '0;
      num_seqs <= '0;
      idx      <= '0;
      progress <= '0;
      leds     <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      w_addr   <= w_addr_d;
      num_seqs <= num_seqs_d;
      idx      <= idx_d;
      progress <= progress_d;
      leds     <= leds_d;
      pass     <= pass_d;
      fail     <= fail_d;
      busy     <= busy_d;
    end
  end

  // Sequence store; writes past DEPTH wrap onto the oldest entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[w_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_seq_matcher.sv
// Scoreboard bench for seq_matcher: stimulus queues expected outputs per cycle, a negedge monitor compares.
module tb_seq_matcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, ld_valid, in_valid;
  logic [1:0] ld_data, in_data;
  logic [1:0] leds;
  logic       pass, fail, busy;
  logic [3:0] num_seqs, progress;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         due;
    string      name;
    logic [1:0] leds;
    logic       pass, fail, busy;
    logic [3:0] num, prog;
  } exp_t;

  exp_t sb[$];

  seq_matcher #(.TIMEOUT_COUNT(24'd20)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .in_valid(in_valid), .in_data(in_data),
    .leds(leds), .pass(pass), .fail(fail), .busy(busy),
    .num_seqs(num_seqs), .progress(progress)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (e.due != cyc || leds !== e.leds || pass !== e.pass || fail !== e.fail ||
          busy !== e.busy || num_seqs !== e.num || progress !== e.prog) begin
        errors = errors + 1;
        $display("FAIL %s @%0d: got leds=%b pass=%b fail=%b busy=%b num=%0d prog=%0d, expected leds=%b pass=%b fail=%b busy=%b num=%0d prog=%0d (due %0d)",
                 e.name, cyc, leds, pass, fail, busy, num_seqs, progress,
                 e.leds, e.pass, e.fail, e.busy, e.num, e.prog, e.due);
      end
    end
  end

  task automatic check_now(input string name, input logic [1:0] l, input logic p,
                           input logic f, input logic b, input logic [3:0] n,
                           input logic [3:0] pr);
    checks = checks + 1;
    if (leds !== l || pass !== p || fail !== f || busy !== b ||
        num_seqs !== n || progress !== pr) begin
      errors = errors + 1;
      $display("FAIL %s @%0d: got leds=%b pass=%b fail=%b busy=%b num=%0d prog=%0d, expected leds=%b pass=%b fail=%b busy=%b num=%0d prog=%0d",
               name, cyc, leds, pass, fail, busy, num_seqs, progress,
               l, p, f, b, n, pr);
    end
  endtask

  task automatic push(input int due, input string name, input logic [1:0] l,
                      input logic p, input logic f, input logic b,
                      input logic [3:0] n, input logic [3:0] pr);
    exp_t e;
    e.due = due; e.name = name; e.leds = l; e.pass = p; e.fail = f;
    e.busy = b; e.num = n; e.prog = pr;
    sb.push_back(e);
  endtask

  task automatic expect_next(input string name, input logic [1:0] l, input logic p,
                             input logic f, input logic b, input logic [3:0] n,
                             input logic [3:0] pr);
    push(cyc + 1, name, l, p, f, b, n, pr);
  endtask

  task automatic drive(input logic c, input logic l, input logic [1:0] ld,
                       input logic v, input logic [1:0] d);
    @(negedge clk);
    clr = c; ld_valid = l; ld_data = ld; in_valid = v; in_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 0, 2'b00);
  endtask

  task automatic load(input logic [1:0] d, input logic [3:0] n);
    drive(0, 1, d, 0, 2'b00);
    expect_next("load", 2'b00, 0, 0, 0, n, 4'd0);
  endtask

  task automatic do_clr();
    drive(1, 0, 2'b00, 0, 2'b00);
    expect_next("clr", 2'b00, 0, 0, 0, 4'd0, 4'd0);
  endtask

  initial begin
    int k;
    logic [1:0] seq10 [10];
    logic [1:0] pr8 [8];
    seq10 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    pr8   = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rst_n = 1'b0;
    clr = 0; ld_valid = 0; ld_data = 0; in_valid = 0; in_data = 0;
    @(posedge clk); #2;
    check_now("reset", 2'b00, 0, 0, 0, 4'd0, 4'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic pass: load 01,10,11 then press the same
    load(2'b01, 4'd1); load(2'b10, 4'd2); load(2'b11, 4'd3);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("p1_check", 2'b01, 0, 0, 1, 4'd3, 4'd1);
    drive(0, 0, 2'b00, 1, 2'b10); expect_next("p2_check", 2'b10, 0, 0, 1, 4'd3, 4'd2);
    drive(0, 0, 2'b00, 1, 2'b11); expect_next("p3_pass", 2'b01, 1, 0, 0, 4'd3, 4'd3);
    drive(0, 0, 2'b00, 0, 2'b00); expect_next("pass_hold", 2'b01, 1, 0, 0, 4'd3, 4'd3);
    drive(0, 1, 2'b00, 0, 2'b00); expect_next("load_in_pass", 2'b01, 1, 0, 0, 4'd3, 4'd3);

    // Fail then retry from FAIL
    do_clr();
    load(2'b01, 4'd1); load(2'b10, 4'd2); load(2'b11, 4'd3);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("f_p1", 2'b01, 0, 0, 1, 4'd3, 4'd1);
    drive(0, 0, 2'b00, 1, 2'b11); expect_next("f_fail", 2'b10, 0, 1, 0, 4'd3, 4'd1);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("r_p1", 2'b01, 0, 0, 1, 4'd3, 4'd1);
    drive(0, 0, 2'b00, 1, 2'b10); expect_next("r_p2", 2'b10, 0, 0, 1, 4'd3, 4'd2);
    drive(0, 0, 2'b00, 1, 2'b11); expect_next("r_pass", 2'b01, 1, 0, 0, 4'd3, 4'd3);

    // Overflow: 10 loads wrap onto mem[0], mem[1]
    do_clr();
    for (int i = 0; i < 10; i++) load(seq10[i], (i < 8) ? 4'(i + 1) : 4'd8);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 2'b00, 1, pr8[i]);
      expect_next("wrap_check", pr8[i], 0, 0, 1, 4'd8, 4'(i + 1));
    end
    drive(0, 0, 2'b00, 1, pr8[7]); expect_next("wrap_pass", 2'b01, 1, 0, 0, 4'd8, 4'd8);

    // Simultaneous load and press in ARMED: press wins
    do_clr();
    load(2'b11, 4'd1);
    drive(0, 1, 2'b00, 1, 2'b11); expect_next("ld_vs_in", 2'b01, 1, 0, 0, 4'd1, 4'd1);
    // clr during CHECK, with a competing load
    do_clr();
    load(2'b01, 4'd1); load(2'b10, 4'd2);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("c_check", 2'b01, 0, 0, 1, 4'd2, 4'd1);
    drive(1, 1, 2'b11, 0, 2'b00); expect_next("clr_check", 2'b00, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("idle_press", 2'b00, 0, 0, 0, 4'd0, 4'd0);

    // Inactivity in CHECK
    load(2'b01, 4'd1); load(2'b10, 4'd2);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("t_check", 2'b01, 0, 0, 1, 4'd2, 4'd1);
    k = cyc;
`ifdef SEQ_MATCHER_TIMEOUT_EN
    push(k + 21, "t_before", 2'b01, 0, 0, 1, 4'd2, 4'd1);
    push(k + 22, "t_fail", 2'b10, 0, 1, 0, 4'd2, 4'd1);
    idle(30);
    check_now("t_expired", 2'b10, 0, 1, 0, 4'd2, 4'd1);
`else
    push(k + 1000, "t_wait", 2'b01, 0, 0, 1, 4'd2, 4'd1);
    idle(1005);
    check_now("t_still_busy", 2'b01, 0, 0, 1, 4'd2, 4'd1);
`endif

    // Async reset mid-attempt
    do_clr();
    load(2'b01, 4'd1); load(2'b10, 4'd2); load(2'b11, 4'd3);
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("a_check", 2'b01, 0, 0, 1, 4'd3, 4'd1);
    drive(0, 0, 2'b00, 0, 2'b00);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst", 2'b00, 0, 0, 0, 4'd0, 4'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 2'b00, 1, 2'b01); expect_next("post_rst_p1", 2'b00, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 2'b00, 1, 2'b10); expect_next("post_rst_p2", 2'b00, 0, 0, 0, 4'd0, 4'd0);
    load(2'b11, 4'd1);
    drive(0, 0, 2'b00, 1, 2'b11); expect_next("post_rst_pass", 2'b01, 1, 0, 0, 4'd1, 4'd1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
